cfg_loader: RTL and testbench

Serial configuration loader that sits directly upstream of the array of logic blocks. It receives a framed serial bitstream, assembles per-block 5-bit config words (4-bit LUT memory plus a sync-enable bit) in a shadow register, and checks even parity over the payload. On a clean frame it commits all words atomically to the `cfg` inputs of the logic blocks. A corrupt or aborted frame never disturbs the active configuration.

---
 rtl/cfg_loader_pkg.sv | 22 ++
 rtl/cfg_sync_detect.sv | 32 +++
 rtl/cfg_loader.sv | 138 +++++++++++++
 tb/tb_cfg_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the serial configuration loader.
// Holds the FSM state encoding, default geometry and the block slice helper.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam int DEF_NUM_BLOCKS = 4;
    localparam int DEF_CFG_W      = 5;
    localparam int P              = DEF_NUM_BLOCKS * DEF_CFG_W;

    localparam logic [7:0] DEF_SYNC = 8'hA5;

    // Lowest bit position of block i's word inside the packed config vector.
    function automatic int block_lo(input int i, input int cfg_w);
        return i * cfg_w;
    endfunction

endpackage

// File: rtl/cfg_sync_detect.sv
// Sliding 8-bit window over the serial stream that flags the frame start pattern.
// The window empties itself on a hit so a new search starts from a clean slate.
module cfg_sync_detect
    import cfg_loader_pkg::*;
#(
    parameter logic [7:0] SYNC = DEF_SYNC
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic clear,
    input  logic bit_in,
    output logic match
);

    logic [7:0] sreg;
    logic [7:0] next_sreg;

    assign next_sreg = {sreg[6:0], bit_in};
    assign match     = shift_en && (next_sreg == SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (clear || match) begin
            sreg <= '0;
        end else if (shift_en) begin
            sreg <= next_sreg;
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Framed serial config loader: hunts for SYNC, shadows the payload LSB first,
// and commits it to the logic blocks only when the trailing even-parity bit agrees.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int         NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int         CFG_W      = DEF_CFG_W,
    parameter logic [7:0] SYNC       = DEF_SYNC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_in,
    input  logic                        bit_valid,
    input  logic                        abort,
    output logic [NUM_BLOCKS*CFG_W-1:0] cfg_out,
    output logic                        cfg_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int PAY_W = NUM_BLOCKS * CFG_W;
    localparam int CNT_W = $clog2(PAY_W + 1);

    state_t             state;
    state_t             next_state;
    logic [PAY_W-1:0]   shadow;
    logic [CNT_W-1:0]   count;
    logic               par;
    logic               sync_match;
    logic               start_frame;
    logic               take_bit;
    logic               commit;
    logic               par_fail;
    logic               discard;

    // The detector only runs while hunting; leaving HUNT or aborting empties it.
    cfg_sync_detect #(
        .SYNC(SYNC)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .shift_en (bit_valid && !abort && (state == HUNT)),
        .clear    (abort || (state != HUNT)),
        .bit_in   (bit_in),
        .match    (sync_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        take_bit    = 1'b0;
        commit      = 1'b0;
        par_fail    = 1'b0;
        discard     = 1'b0;
        case (state)
            HUNT: begin
                if (sync_match) begin
                    next_state  = LOAD;
                    start_frame = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    next_state = HUNT;
                    discard    = 1'b1;
                end else if (bit_valid) begin
                    take_bit = 1'b1;
                    if (count == CNT_W'(PAY_W - 1)) begin
                        next_state = PAR;
                    end
                end
            end
            PAR: begin
                if (abort) begin
                    next_state = HUNT;
                    discard    = 1'b1;
                end else if (bit_valid) begin
                    next_state = HUNT;
                    if (par ^ bit_in) begin
                        par_fail = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            default: next_state = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            count  <= '0;
            par    <= 1'b0;
        end else if (start_frame || discard) begin
            shadow <= '0;
            count  <= '0;
            par    <= 1'b0;
        end else if (take_bit) begin
            shadow[count] <= bit_in;
            count         <= count + 1'b1;
            par           <= par ^ bit_in;
        end
    end

    // The active configuration only ever changes on a parity-clean commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_out   <= '0;
            cfg_valid <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                for (int i = 0; i < NUM_BLOCKS; i++) begin
                    cfg_out[block_lo(i, CFG_W) +: CFG_W] <= shadow[block_lo(i, CFG_W) +: CFG_W];
                end
                cfg_valid <= 1'b1;
                err       <= 1'b0;
            end else if (par_fail) begin
                err <= 1'b1;
            end
        end
    end

    assign busy = (state == LOAD) || (state == PAR);

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboard bench for cfg_loader: frames are driven bit by bit, expected commit
// results are queued as each frame is sent and compared when the frame ends.
module tb_cfg_loader;

    localparam int PAY_W = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic             abort;
    logic [PAY_W-1:0] cfg_out;
    logic             cfg_valid;
    logic             busy;
    logic             done;
    logic             err;

    typedef struct packed {
        logic [PAY_W-1:0] cfg;
        logic             valid;
        logic             err;
        logic             done;
    } exp_t;

    exp_t             sb_q[$];
    logic [PAY_W-1:0] model_cfg;
    logic             model_valid;
    logic             model_err;
    logic [7:0]       sync_pat = 8'hA5;
    int               num_checks = 0;
    int               num_fails  = 0;

    cfg_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .abort     (abort),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle's inputs on the falling edge so the rising edge samples them.
    task automatic applyStimulus(input logic b, input logic v, input logic a);
        @(negedge clk);
        bit_in    = b;
        bit_valid = v;
        abort     = a;
    endtask

    task automatic sendBit(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        applyStimulus(b, 1'b1, 1'b0);
    endtask

    task automatic sendSync(input bit gaps);
        for (int i = 7; i >= 0; i--) sendBit(sync_pat[i], gaps);
    endtask

    task automatic sendNoise();
        logic [6:0] noise;
        noise = 7'b1011010;
        for (int i = 6; i >= 0; i--) sendBit(noise[i], 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        model_cfg   = '0;
        model_valid = 1'b0;
        model_err   = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_cfg"}, 32'(cfg_out), 32'(model_cfg));
        checkOutput({tag, "_valid"}, 32'(cfg_valid), 32'(model_valid));
        checkOutput({tag, "_err"}, 32'(err), 32'(model_err));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Pops the queued expectation for the frame whose parity bit was just accepted.
    task automatic checkResult(input string tag);
        exp_t e;
        applyStimulus(1'b0, 1'b0, 1'b0);
        e = sb_q.pop_front();
        checkOutput({tag, "_done"}, 32'(done), 32'(e.done));
        checkOutput({tag, "_cfg"}, 32'(cfg_out), 32'(e.cfg));
        checkOutput({tag, "_valid"}, 32'(cfg_valid), 32'(e.valid));
        checkOutput({tag, "_err"}, 32'(err), 32'(e.err));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
    endtask

    task automatic sendFrame(input string tag, input logic [PAY_W-1:0] payload,
                             input logic parity, input bit gaps, input bit noise);
        exp_t e;
        if (((^payload) ^ parity) == 1'b0) begin
            model_cfg   = payload;
            model_valid = 1'b1;
            model_err   = 1'b0;
            e.done      = 1'b1;
        end else begin
            model_err = 1'b1;
            e.done    = 1'b0;
        end
        e.cfg   = model_cfg;
        e.valid = model_valid;
        e.err   = model_err;
        sb_q.push_back(e);
        if (noise) sendNoise();
        sendSync(gaps);
        for (int i = 0; i < PAY_W; i++) begin
            sendBit(payload[i], gaps);
            if (i == 0) checkOutput({tag, "_busy_load"}, 32'(busy), 32'd1);
        end
        sendBit(parity, gaps);
        checkResult(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        abort     = 1'b0;
        doReset();
        checkIdle("reset");

        for (int i = 0; i < 10; i++) sendBit(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("nosync_busy", 32'(busy), 32'd0);

        sendFrame("good", 20'h5A3C6, 1'b0, 1'b0, 1'b0);
        checkOutput("block0_xor", 32'(cfg_out[4:0]), 32'h06);

        sendFrame("badpar", 20'hFFFFF, 1'b1, 1'b0, 1'b0);

        sendSync(1'b0);
        for (int i = 0; i < 7; i++) sendBit(1'($urandom_range(0, 1)), 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdle("abort");
        sendFrame("post_abort", 20'h12345, ^20'h12345, 1'b0, 1'b0);

        sendFrame("gaps", 20'h5A3C6, 1'b0, 1'b1, 1'b1);
        sendFrame("a5_payload", 20'h0A5F0, ^20'h0A5F0, 1'b1, 1'b1);

        sendSync(1'b0);
        for (int i = 0; i < 12; i++) sendBit(1'b1, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bit_valid   = 1'b0;
        model_cfg   = '0;
        model_valid = 1'b0;
        model_err   = 1'b0;
        checkIdle("midreset");
        sendFrame("after_reset", 20'hC0FFE, ^20'hC0FFE, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
